fifo_read_arbiter: RTL

- Shares the read side of the asynchronous FIFO among NUM_REQ consumers in the read clock domain.
- Selects one consumer at a time (round-robin) and drives the read logic's remove and syn_flush inputs.
- Counts words read per grant and caps each grant at a burst length.
- Routes each delivered word to the granted consumer as a one-hot valid strobe aligned with RAM read data.

---
 rtl/fifo_read_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fifo_read_arbiter.sv
// Read-side arbiter for the async FIFO: grants one consumer at a time, caps bursts, routes rd_valid.
// Define FIFO_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module fifo_read_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 4
) (
    input  logic               clk_out,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               flush_req,
    input  logic               empty,
    input  logic               read_enable,
    output logic               remove,
    output logic               syn_flush,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] rd_valid,
    output logic               busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {IDLE, ARB, GRANT, RELEASE, FLUSH} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   burst_cnt;
    logic [NUM_REQ-1:0] winner;
    logic               burst_done;
    logic               owner_gone;

    assign burst_done = read_enable && ((burst_cnt + CNT_W'(1)) == BURST_LIM);
    assign owner_gone = ~|(req & grant);

`ifdef FIFO_ARB_FIXED_PRIO_EN
    always_comb begin
        logic found;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] grant_idx;

    // Scan starts just after the previous owner and wraps, giving round-robin fairness.
    always_comb begin
        logic [IDX_W-1:0] idx;
        logic             found;
        winner = '0;
        found  = 1'b0;
        idx    = (last == LAST_IDX) ? '0 : last + IDX_W'(1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            last <= LAST_IDX;
        end else if (state == RELEASE) begin
            last <= grant_idx;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                end else if ((|req) && !empty) begin
                    state_nxt = ARB;
                end
            end
            ARB:     state_nxt = (|req) ? GRANT : IDLE;
            GRANT: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                end else if (burst_done || owner_gone || empty) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered with the state change.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remove    <= 1'b0;
            syn_flush <= 1'b0;
            grant     <= '0;
            rd_valid  <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            remove    <= (state_nxt == GRANT);
            syn_flush <= (state_nxt == FLUSH);
            busy      <= (state_nxt != IDLE);
            rd_valid  <= (state_nxt == FLUSH) ? '0 : (grant & {NUM_REQ{read_enable}});

            if (state == ARB && state_nxt == GRANT) begin
                grant <= winner;
            end else if (state_nxt != GRANT && state_nxt != RELEASE) begin
                grant <= '0;
            end

            if (state == ARB || state_nxt == FLUSH) begin
                burst_cnt <= '0;
            end else if (state == GRANT && read_enable && burst_cnt != BURST_LIM) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

endmodule
